// File: rtl/kv_pkg.sv
// Shared definitions for the kv_table DNS-filter lookup table: status codes,
// request flag bit positions, entry layout and the 16-bit key fold.
package kv_pkg;

  localparam logic [1:0] STATUS_NONE    = 2'b00;
  localparam logic [1:0] STATUS_SUSPECT = 2'b01;
  localparam logic [1:0] STATUS_ARREST  = 2'b10;

  localparam int FLAG_EN    = 0;
  localparam int FLAG_ST_LO = 1;
  localparam int FLAG_ST_HI = 2;
  localparam int FLAG_RSVD  = 3;

  // Entry is {valid, status[1:0], key}; keys up to KV_KEY_MAX bits are folded.
  localparam int KV_META_W  = 3;
  localparam int KV_KEY_MAX = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } kv_state_t;

  function automatic int kv_entry_w(input int key_size);
    return key_size + KV_META_W;
  endfunction

  function automatic logic [15:0] kv_fold(input logic [KV_KEY_MAX-1:0] key);
    logic [15:0] h;
    h = '0;
    for (int i = 0; i < KV_KEY_MAX / 16; i++) h ^= key[i*16 +: 16];
    return h;
  endfunction

endpackage

// File: rtl/kv_ram.sv
// Simple dual-port RAM for kv_table: one write port, one registered read port,
// read-first when both ports hit the same address on the same edge.
module kv_ram #(
  parameter int DATA_W = 99,
  parameter int ADDR_W = 10
) (
  input  logic              clk156,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk156) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/kv_table.sv
// Direct-mapped SUSPECT/ARREST flow table with a fixed 2-cycle lookup response.
// Optional statistics counters are built when KV_TABLE_STATS_EN is defined.
module kv_table
  import kv_pkg::*;
#(
  parameter int KEY_SIZE   = 96,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk156,
  input  logic                eth_rst,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                init_done,
  output logic [63:0]         stats
);

  localparam int ENTRY_W = kv_entry_w(KEY_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  kv_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic                  clr_we;

  logic [1:0]            st_p0;
  logic                  op_p0;
  logic [15:0]           fold_p0;
  logic [ADDR_WIDTH-1:0] idx_p0;

  logic                  vld_p1, run_p1, act_p1;
  logic [KEY_SIZE-1:0]   key_p1;
  logic [1:0]            st_p1;
  logic [ADDR_WIDTH-1:0] idx_p1;

  logic                  byp_vld_q;
  logic [ADDR_WIDTH-1:0] byp_idx_q;
  logic [ENTRY_W-1:0]    byp_entry_q;

  logic [ENTRY_W-1:0]    rd_entry_p1, ent_p1, dec_entry_p1;
  logic                  ent_valid_p1;
  logic [1:0]            ent_st_p1, prior_p1;
  logic [KEY_SIZE-1:0]   ent_key_p1;
  logic                  hit_p1, dec_we_p1, evict_p1, upgrade_p1;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ENTRY_W-1:0]    wr_data;
  logic                  rsvd_unused;

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (clr_ptr_q == LAST_IDX) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    clr_we    = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: clr_we    = 1'b1;
      ST_RUN:  init_done = 1'b1;
    endcase
  end

  // Stage p0: classify the request and issue the RAM read
  assign st_p0   = in_flag[FLAG_ST_HI:FLAG_ST_LO];
  assign op_p0   = in_valid & in_flag[FLAG_EN] &
                   ((st_p0 == STATUS_SUSPECT) | (st_p0 == STATUS_ARREST));
  assign fold_p0 = kv_fold(KV_KEY_MAX'(in_key));
  assign idx_p0  = fold_p0[ADDR_WIDTH-1:0];
  assign rsvd_unused = ^{in_flag[FLAG_RSVD], fold_p0};

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      vld_p1 <= 1'b0;
      run_p1 <= 1'b0;
    end else begin
      vld_p1 <= op_p0;
      run_p1 <= (state_q == ST_RUN);
    end
  end

  always_ff @(posedge clk156) begin
    key_p1 <= in_key;
    st_p1  <= st_p0;
    idx_p1 <= idx_p0;
  end

  // Stage p1: the RAM read raced last cycle's write, so the bypass wins on a match
  assign ent_p1 = (byp_vld_q && (byp_idx_q == idx_p1)) ? byp_entry_q : rd_entry_p1;
  assign {ent_valid_p1, ent_st_p1, ent_key_p1} = ent_p1;
  assign act_p1   = vld_p1 & run_p1;
  assign hit_p1   = ent_valid_p1 && (ent_key_p1 == key_p1);
  assign prior_p1 = hit_p1 ? ent_st_p1 : STATUS_NONE;

  always_comb begin
    dec_we_p1    = 1'b0;
    dec_entry_p1 = {1'b1, STATUS_SUSPECT, key_p1};
    evict_p1     = 1'b0;
    upgrade_p1   = 1'b0;
    if (act_p1) begin
      case (st_p1)
        STATUS_SUSPECT: if (!hit_p1) begin
          dec_we_p1 = 1'b1;
          evict_p1  = ent_valid_p1;
        end
        STATUS_ARREST: if (hit_p1 && (ent_st_p1 == STATUS_SUSPECT)) begin
          dec_we_p1    = 1'b1;
          upgrade_p1   = 1'b1;
          dec_entry_p1 = {1'b1, STATUS_ARREST, key_p1};
        end
        default: ;
      endcase
    end
  end

  assign wr_en   = ~eth_rst & (clr_we | dec_we_p1);
  assign wr_addr = clr_we ? clr_ptr_q : idx_p1;
  assign wr_data = clr_we ? '0 : dec_entry_p1;

  kv_ram #(
    .DATA_W (ENTRY_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk156  (clk156),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_p0),
    .rd_data (rd_entry_p1)
  );

  always_ff @(posedge clk156) begin
    if (eth_rst) byp_vld_q <= 1'b0;
    else         byp_vld_q <= dec_we_p1;
  end

  always_ff @(posedge clk156) begin
    byp_idx_q   <= idx_p1;
    byp_entry_q <= dec_entry_p1;
  end

  // Stage p2: registered response
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      out_valid <= 1'b0;
      out_flag  <= 4'b0000;
    end else begin
      out_valid <= vld_p1;
      out_flag  <= act_p1 ? {1'b0, prior_p1, hit_p1} : 4'b0000;
    end
  end

`ifdef KV_TABLE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q, evict_cnt_q, upg_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
      upg_cnt_q   <= '0;
    end else begin
      hit_cnt_q   <= sat_inc(hit_cnt_q,   act_p1 &  hit_p1);
      miss_cnt_q  <= sat_inc(miss_cnt_q,  act_p1 & ~hit_p1);
      evict_cnt_q <= sat_inc(evict_cnt_q, evict_p1);
      upg_cnt_q   <= sat_inc(upg_cnt_q,   upgrade_p1);
    end
  end

  assign stats = {hit_cnt_q, miss_cnt_q, evict_cnt_q, upg_cnt_q};
`else
  assign stats = 64'd0;
`endif

endmodule

// File: tb/tb_kv_table.sv
// Scoreboard bench for kv_table: requests push expected responses, a negedge
// monitor pops and compares them, including the response cycle.
module tb_kv_table;

  localparam int KEY_SIZE   = 96;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic [3:0] SUS = 4'b0011;
  localparam logic [3:0] ARR = 4'b0101;

  logic                clk156 = 1'b0;
  logic                eth_rst;
  logic [KEY_SIZE-1:0] in_key;
  logic [3:0]          in_flag;
  logic                in_valid;
  logic                out_valid;
  logic [3:0]          out_flag;
  logic                init_done;
  logic [63:0]         stats;

  kv_table #(
    .KEY_SIZE   (KEY_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk156    (clk156),
    .eth_rst   (eth_rst),
    .in_key    (in_key),
    .in_flag   (in_flag),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_flag  (out_flag),
    .init_done (init_done),
    .stats     (stats)
  );

  always #5 clk156 = ~clk156;

  typedef struct {
    logic [3:0] flag;
    int         due;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic                m_v [DEPTH];
  logic [1:0]          m_s [DEPTH];
  logic [KEY_SIZE-1:0] m_k [DEPTH];
  int n_hit, n_miss, n_evict, n_upg;

  logic [KEY_SIZE-1:0] K, K1, K2, K3, K4, K6;
  logic [KEY_SIZE-1:0] pool [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] fold(input logic [KEY_SIZE-1:0] k);
    logic [15:0] h = 16'h0;
    for (int w = 0; w < KEY_SIZE / 16; w++) h ^= k[w*16 +: 16];
    return h;
  endfunction

  // Reference behaviour: requests take effect strictly in issue order.
  function automatic logic [3:0] model_op(input logic [KEY_SIZE-1:0] k, input logic [1:0] st);
    int idx;
    logic hit;
    logic [1:0] prior;
    if (cyc < DEPTH) return 4'b0000;
    idx   = int'(fold(k)) % DEPTH;
    hit   = m_v[idx] && (m_k[idx] == k);
    prior = hit ? m_s[idx] : 2'b00;
    if (hit) n_hit++; else n_miss++;
    if (st == 2'b01 && !hit) begin
      if (m_v[idx]) n_evict++;
      m_v[idx] = 1'b1;
      m_s[idx] = 2'b01;
      m_k[idx] = k;
    end
    if (st == 2'b10 && hit && m_s[idx] == 2'b01) begin
      m_s[idx] = 2'b10;
      n_upg++;
    end
    return {1'b0, prior, hit};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0;
      m_s[i] = 2'b00;
      m_k[i] = '0;
    end
    n_hit = 0; n_miss = 0; n_evict = 0; n_upg = 0;
  endtask

  task automatic tick();
    @(posedge clk156);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input logic [KEY_SIZE-1:0] k, input logic [3:0] f, input logic v,
                     input logic use_want, input logic [3:0] want);
    logic [3:0] m;
    exp_t e;
    in_key   = k;
    in_flag  = f;
    in_valid = v;
    if (v && f[0] && (f[2:1] == 2'b01 || f[2:1] == 2'b10)) begin
      m      = model_op(k, f[2:1]);
      e.flag = use_want ? want : m;
      e.due  = cyc + 2;
      expq.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_init(input string name);
    while (!init_done && cyc < 4 * DEPTH) tick();
    check(name, 64'(cyc), 64'(DEPTH));
  endtask

  task automatic check_stats(input string name);
    logic [63:0] w;
`ifdef KV_TABLE_STATS_EN
    w = {16'(n_hit), 16'(n_miss), 16'(n_evict), 16'(n_upg)};
`else
    w = 64'd0;
`endif
    check(name, stats, w);
  endtask

  always @(negedge clk156) begin : mon
    exp_t e;
    while (expq.size() > 0 && expq[0].due < cyc) begin
      e = expq.pop_front();
      check("resp_missing", 64'(0), 64'(e.flag) | 64'h10);
    end
    if (out_valid) begin
      if (expq.size() == 0) begin
        check("resp_unexpected", 64'(out_flag) | 64'h10, 64'(0));
      end else begin
        e = expq.pop_front();
        check("resp_flag", 64'(out_flag), 64'(e.flag));
        check("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    K  = {32'hC0A80164, 32'hC0A80131, 16'd12345, 16'd0};
    K1 = 96'h0A000001_0A000002_0035_0000;
    K2 = K1 ^ 96'h0000_0000_0000_0000_0001_0001;
    K3 = 96'h08080808_01020304_0050_0000;
    K4 = 96'hAC100005_AC10000A_01BB_0000;
    K6 = 96'h01010101_02020202_1F90_0000;
    pool[0] = K;  pool[1] = K1; pool[2] = K2; pool[3] = K3;
    pool[4] = K4; pool[5] = K6;
    pool[6] = K ^ 96'h0000_0000_0000_0000_0001_0001;
    pool[7] = K3 ^ 96'h0000_0000_0000_0042_0042_0000;

    in_key = '0; in_flag = 4'b0000; in_valid = 1'b0;
    eth_rst = 1'b1;
    idle(2);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_flag",  64'(out_flag),  64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_stats",     stats,          64'd0);
    eth_rst = 1'b0;
    cyc = 0;
    model_clear();

    // Request during the clear sequence
    idle(5);
    req(K, SUS, 1'b1, 1'b1, 4'b0000);
    wait_init("init_cycles");
    idle(2);

    // Suspect -> arrest -> block
    req(K, SUS, 1'b1, 1'b1, 4'b0000); idle(3);
    req(K, ARR, 1'b1, 1'b1, 4'b0011); idle(3);
    req(K, SUS, 1'b1, 1'b1, 4'b0101); idle(3);

    // ARREST on unknown key creates nothing
    req(K3, ARR, 1'b1, 1'b1, 4'b0000); idle(3);
    req(K3, SUS, 1'b1, 1'b1, 4'b0000); idle(3);

    // Collision eviction
    req(K1, SUS, 1'b1, 1'b1, 4'b0000); idle(3);
    req(K2, SUS, 1'b1, 1'b1, 4'b0000); idle(3);
    req(K1, ARR, 1'b1, 1'b1, 4'b0000); idle(3);
    check_stats("stats_directed");

    // Back-to-back hazard through the bypass
    req(K4, SUS, 1'b1, 1'b1, 4'b0000);
    req(K4, ARR, 1'b1, 1'b1, 4'b0011);
    req(K4, SUS, 1'b1, 1'b1, 4'b0101);
    idle(3);

    // Ignored requests: no response and no write
    req(K6, SUS, 1'b1, 1'b1, 4'b0000);  idle(2);
    req(K6, 4'b0100, 1'b1, 1'b0, 4'b0000);
    req(K6, 4'b0111, 1'b1, 1'b0, 4'b0000);
    req(K6, 4'b0001, 1'b1, 1'b0, 4'b0000);
    req(K6, ARR,     1'b0, 1'b0, 4'b0000);
    idle(2);
    req(K6, SUS, 1'b1, 1'b1, 4'b0011);  idle(3);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] f;
      f = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1) != 0) ? SUS : ARR)
                                     : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) f[3] = 1'b1;
      req(pool[$urandom_range(0, 7)], f, 1'($urandom_range(0, 9) != 0), 1'b0, 4'b0000);
    end
    idle(4);
    check_stats("stats_random");

    // Reset one cycle after a request: its response must never appear
    in_key = K; in_flag = SUS; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    eth_rst  = 1'b1;
    expq.delete();
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_init_done", 64'(init_done), 64'(0));
    check("midrst_stats",     stats,          64'd0);
    eth_rst = 1'b0;
    cyc = 0;
    model_clear();
    wait_init("reinit_cycles");
    idle(2);
    req(K, SUS, 1'b1, 1'b1, 4'b0000); idle(3);
    req(K, ARR, 1'b1, 1'b1, 4'b0011); idle(4);
    check_stats("stats_after_reset");

    check("pending_at_end", 64'(expq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
